// File: rtl/ps2_scan_rx_if.sv
// Scancode event stream between ps2_scan_rx (master) and its consumer (slave).
// Carries the FIFO head plus the valid/ready handshake.
interface ps2_scan_rx_if;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_code;
   logic       out_ext;
   logic       out_brk;
   logic       out_err;

   modport master (output out_valid, out_code, out_ext, out_brk, out_err, input out_ready);
   modport slave  (input out_valid, out_code, out_ext, out_brk, out_err, output out_ready);
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: clock filter, 11-bit deframer, E0/F0 folding, FWFT event FIFO.
// Optional frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_scan_rx #(
   parameter int DEB_CYCLES     = 8,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                        computerClk,
   input  logic                        rst,
   input  logic                        PS2_KBCLK,
   input  logic                        PS2_KBDAT,
   ps2_scan_rx_if.master               evt,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        timeout
);
   localparam int DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   function automatic logic frame_good(input logic [7:0] d, input logic p, input logic s);
      return (^{d, p}) & s;
   endfunction

   logic           kbclk_p0, kbclk_p1, kbdat_p0, kbdat_p1;
   logic           filt, filt_d, strobe;
   logic [DCW-1:0] deb_cnt;
   state_t         state, state_n;
   logic [2:0]     bit_cnt;
   logic [7:0]     shift;
   logic           par;
   logic           ext, brk, ext_n, brk_n;
   logic           push, abort, good;
   logic [10:0]    ev;
   logic [10:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic           full, pop, wr;

   // stage p0/p1: two-flop synchronisers
   always_ff @(posedge computerClk or posedge rst) begin
      if (rst) begin
         kbclk_p0 <= 1'b1;
         kbclk_p1 <= 1'b1;
         kbdat_p0 <= 1'b1;
         kbdat_p1 <= 1'b1;
      end else begin
         kbclk_p0 <= PS2_KBCLK;
         kbclk_p1 <= kbclk_p0;
         kbdat_p0 <= PS2_KBDAT;
         kbdat_p1 <= kbdat_p0;
      end
   end

   // filter stage: level changes only after DEB_CYCLES consecutive differing samples
   always_ff @(posedge computerClk or posedge rst) begin
      if (rst) begin
         filt    <= 1'b1;
         filt_d  <= 1'b1;
         strobe  <= 1'b0;
         deb_cnt <= '0;
      end else begin
         filt_d <= filt;
         strobe <= filt_d & ~filt;
         if (kbclk_p1 != filt) begin
            if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
               filt    <= kbclk_p1;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

`ifdef PS2_WATCHDOG_EN
   logic [TW-1:0] wd_cnt;
   assign abort = (state != IDLE) && !strobe && (wd_cnt == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge computerClk or posedge rst) begin
      if (rst) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= abort;
         if (state == IDLE || strobe || abort) wd_cnt <= '0;
         else                                  wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign abort   = 1'b0;
   assign timeout = 1'b0;
`endif

   assign good = frame_good(shift, par, kbdat_p1);
   assign ev   = {~good, ext, brk, shift};

   always_comb begin
      state_n = state;
      push    = 1'b0;
      ext_n   = ext;
      brk_n   = brk;
      if (abort) begin
         state_n = IDLE;
         ext_n   = 1'b0;
         brk_n   = 1'b0;
      end else if (strobe) begin
         case (state)
            IDLE:    if (!kbdat_p1) state_n = DATA;
            DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
            PARITY:  state_n = STOP;
            STOP: begin
               state_n = IDLE;
               if (good && shift == 8'hE0) begin
                  ext_n = 1'b1;
               end else if (good && shift == 8'hF0) begin
                  brk_n = 1'b1;
               end else begin
                  push  = 1'b1;
                  ext_n = 1'b0;
                  brk_n = 1'b0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // frame stage: control state and prefix flags
   always_ff @(posedge computerClk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ext     <= 1'b0;
         brk     <= 1'b0;
         bit_cnt <= '0;
      end else begin
         state <= state_n;
         ext   <= ext_n;
         brk   <= brk_n;
         if (strobe && state == IDLE) bit_cnt <= '0;
         else if (strobe && state == DATA) bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge computerClk) begin
      if (strobe && state == DATA)   shift <= {kbdat_p1, shift[7:1]};
      if (strobe && state == PARITY) par   <= kbdat_p1;
   end

   // write stage: FIFO; a push at full only lands if the head leaves in the same cycle
   assign full = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign pop  = evt.out_valid & evt.out_ready;
   assign wr   = push & (~full | pop);

   always_ff @(posedge computerClk) begin
      if (wr) mem[wr_ptr] <= ev;
   end

   always_ff @(posedge computerClk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (push && !wr) overflow <= 1'b1;
      end
   end

   assign evt.out_valid = (fifo_count != '0);
   assign evt.out_code  = evt.out_valid ? mem[rd_ptr][7:0] : 8'h00;
   assign evt.out_brk   = evt.out_valid ? mem[rd_ptr][8]   : 1'b0;
   assign evt.out_ext   = evt.out_valid ? mem[rd_ptr][9]   : 1'b0;
   assign evt.out_err   = evt.out_valid ? mem[rd_ptr][10]  : 1'b0;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx; events are logged as {err,ext,brk,code}.
// Define PS2_WATCHDOG_EN for both files to exercise the watchdog.
module tb_ps2_scan_rx;
   localparam int DEB  = 8;
   localparam int DEP  = 8;
   localparam int TO   = 300;
   localparam int HALF = 20;
   localparam int GAP  = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       kbclk = 1'b1;
   logic       kbdat = 1'b1;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       timeout;

   ps2_scan_rx_if evt ();

   ps2_scan_rx #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEP), .TIMEOUT_CYCLES(TO)) dut (
      .computerClk(clk),
      .rst(rst),
      .PS2_KBCLK(kbclk),
      .PS2_KBDAT(kbdat),
      .evt(evt),
      .fifo_count(fifo_count),
      .overflow(overflow),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          lat = -1;
   int          peak = 0;
   int          to_cnt = 0;
   logic [10:0] got_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // sample the state that the coming edge acts on, then advance one cycle
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         if (evt.out_valid && evt.out_ready)
            got_q.push_back({evt.out_err, evt.out_ext, evt.out_brk, evt.out_code});
         if (32'(fifo_count) > peak) peak = 32'(fifo_count);
         if (timeout) to_cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input logic glitch, input logic measure);
      logic v0;
      kbdat = b;
      if (glitch) begin
         tick(5); kbclk = 1'b0; tick(1); kbclk = 1'b1; tick(HALF - 6);
      end else begin
         tick(HALF);
      end
      v0 = evt.out_valid;
      kbclk = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
         if (glitch && i == 15) kbclk = 1'b1;
         if (glitch && i == 16) kbclk = 1'b0;
         tick(1);
         if (measure && lat < 0 && evt.out_valid && !v0) lat = i;
      end
      kbclk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopv, input logic glitch);
      logic p;
      p = ~(^d) ^ pflip;
      send_bit(1'b0, glitch, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i], glitch, 1'b0);
      send_bit(p, glitch, 1'b0);
      lat = -1;
      send_bit(stopv, glitch, 1'b1);
      kbdat = 1'b1;
      tick(GAP);
   endtask

   task automatic chk_ev(input string tag, input logic [10:0] exp);
      chk({tag, "_avail"}, 32'(got_q.size() > 0), 32'd1);
      if (got_q.size() > 0) chk(tag, 32'(got_q.pop_front()), 32'(exp));
   endtask

   initial begin
      evt.out_ready = 1'b0;
      rst = 1'b1;
      tick(3);
      chk("rst_valid", 32'(evt.out_valid), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_to", 32'(timeout), 32'd0);
      chk("rst_code", 32'(evt.out_code), 32'd0);
      chk("rst_flags", 32'({evt.out_err, evt.out_ext, evt.out_brk}), 32'd0);
      rst = 1'b0;
      tick(5);

      evt.out_ready = 1'b1;
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("lat_1c", 32'(lat), 32'(DEB + 4));
      chk("n_1c", 32'(got_q.size()), 32'd1);
      chk_ev("ev_1c", {3'b000, 8'h1C});

      peak = 0;
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("n_brk", 32'(got_q.size()), 32'd1);
      chk_ev("ev_brk", {3'b001, 8'h1C});
      chk("peak_brk", 32'(peak), 32'd1);

      send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("n_extbrk", 32'(got_q.size()), 32'd2);
      chk_ev("ev_extbrk", {3'b011, 8'h75});
      chk_ev("ev_after", {3'b000, 8'h1C});

      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      chk_ev("ev_par", {3'b100, 8'h1C});
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      chk_ev("ev_stop", {3'b100, 8'h5A});
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk_ev("ev_errbrk", {3'b101, 8'h33});
      chk_ev("ev_errclr", {3'b000, 8'h1C});

      send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
      chk("n_glitch", 32'(got_q.size()), 32'd1);
      chk_ev("ev_glitch", {3'b000, 8'h1C});

      evt.out_ready = 1'b0;
      for (int k = 0; k < DEP + 1; k++) send_frame(8'h16, 1'b0, 1'b1, 1'b0);
      chk("full_count", 32'(fifo_count), 32'(DEP));
      chk("full_ovf", 32'(overflow), 32'd1);
      chk("full_head", 32'({evt.out_valid, evt.out_code}), 32'h116);
      evt.out_ready = 1'b1;
      tick(20);
      chk("drain_n", 32'(got_q.size()), 32'(DEP));
      for (int k = 0; k < DEP; k++) chk_ev("drain_ev", {3'b000, 8'h16});
      chk("drain_ovf", 32'(overflow), 32'd1);
      chk("drain_count", 32'(fifo_count), 32'd0);
      chk("drain_code", 32'({evt.out_valid, evt.out_code}), 32'd0);

      send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      kbdat = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(GAP);
      chk("mrst_ovf", 32'(overflow), 32'd0);
      send_frame(8'h29, 1'b0, 1'b1, 1'b0);
      chk("n_mrst", 32'(got_q.size()), 32'd1);
      chk_ev("ev_mrst", {3'b000, 8'h29});

`ifdef PS2_WATCHDOG_EN
      send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
      to_cnt = 0;
      send_bit(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0, 1'b0);
      kbdat = 1'b1;
      tick(TO + 100);
      chk("wd_pulses", 32'(to_cnt), 32'd1);
      chk("wd_nopush", 32'(got_q.size()), 32'd0);
      send_frame(8'h29, 1'b0, 1'b1, 1'b0);
      chk_ev("ev_wd", {3'b000, 8'h29});
`else
      chk("no_timeout", 32'(to_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
